// File: rtl/sipo_comma_align.sv
// Receive deserializer: shifts in an LSB-first bitstream, hunts for a K28.5 comma
// in either disparity, and emits word-aligned 10-bit code groups once locked.
module sipo_comma_align #(
  parameter logic [9:0]  COMMA_P   = 10'b0101111100,
  parameter logic [9:0]  COMMA_N   = 10'b1010000011,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       serial_valid,
  output logic [9:0] parallel_out,
  output logic       data_valid,
  output logic       comma_det,
  output logic       aligned
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state_q;
  logic [9:0] shreg_q;
  logic [9:0] shreg_d;
  logic [3:0] phase_q;
  logic [3:0] err_cnt_q;
  logic       is_comma;
  logic       err_hit;

  assign shreg_d  = {serial_in, shreg_q[9:1]};
  assign is_comma = (shreg_d == COMMA_P) || (shreg_d == COMMA_N);
  assign err_hit  = ({1'b0, err_cnt_q} + 5'd1) == 5'(ERR_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      shreg_q      <= '0;
      phase_q      <= '0;
      err_cnt_q    <= '0;
      parallel_out <= '0;
      data_valid   <= 1'b0;
      comma_det    <= 1'b0;
      aligned      <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      comma_det  <= 1'b0;
      if (serial_valid) begin
        shreg_q <= shreg_d;
        case (state_q)
          HUNT: begin
            if (is_comma) begin
              parallel_out <= shreg_d;
              data_valid   <= 1'b1;
              comma_det    <= 1'b1;
              phase_q      <= '0;
              err_cnt_q    <= '0;
              state_q      <= LOCKED;
              aligned      <= 1'b1;
            end
          end
          LOCKED: begin
            if (phase_q == 4'd9) begin
              parallel_out <= shreg_d;
              data_valid   <= 1'b1;
              comma_det    <= is_comma;
              phase_q      <= '0;
              if (is_comma) err_cnt_q <= '0;
            end else if (is_comma) begin
              // Misaligned comma: the limit-reaching one drops lock without realigning here.
              if (err_hit) begin
                state_q   <= HUNT;
                aligned   <= 1'b0;
                err_cnt_q <= '0;
                phase_q   <= '0;
              end else begin
                err_cnt_q <= err_cnt_q + 4'd1;
                phase_q   <= phase_q + 4'd1;
              end
            end else begin
              phase_q <= phase_q + 4'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sipo_comma_align.sv
// Scoreboard bench for sipo_comma_align: expected words are queued as the final
// bit of each word is driven and checked when data_valid pulses.
module tb_sipo_comma_align;

  localparam logic [9:0] P = 10'b0101111100;
  localparam logic [9:0] N = 10'b1010000011;

  typedef struct packed {
    logic [9:0] word;
    logic       comma;
    logic       algn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       serial_in = 1'b0;
  logic       serial_valid = 1'b0;
  logic [9:0] parallel_out;
  logic       data_valid;
  logic       comma_det;
  logic       aligned;

  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  sipo_comma_align #(.COMMA_P(P), .COMMA_N(N), .ERR_LIMIT(4)) dut (
    .clk(clk),
    .rst(rst),
    .serial_in(serial_in),
    .serial_valid(serial_valid),
    .parallel_out(parallel_out),
    .data_valid(data_valid),
    .comma_det(comma_det),
    .aligned(aligned)
  );

  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on each data_valid pulse.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (data_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_data_valid got word=%h comma=%b exp=no output", parallel_out, comma_det);
        end else begin
          mon_e = sb.pop_front();
          if ({parallel_out, comma_det, aligned} !== mon_e) begin
            failures++;
            $display("FAIL sb_word got word=%h comma=%b aligned=%b exp word=%h comma=%b aligned=%b",
                     parallel_out, comma_det, aligned, mon_e.word, mon_e.comma, mon_e.algn);
          end
        end
      end else begin
        checks++;
        if (comma_det !== 1'b0) begin
          failures++;
          $display("FAIL stray_comma_det got=%b exp=0", comma_det);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic b, input logic v);
    @(posedge clk);
    #1;
    serial_in    = b;
    serial_valid = v;
  endtask

  task automatic send_word(input logic [9:0] w, input int unsigned gap,
                           input logic expect_out, input logic exp_comma);
    for (int i = 0; i < 10; i++) begin
      drive(w[i], 1'b1);
      if (i == 9 && expect_out) sb.push_back({w, exp_comma, 1'b1});
      repeat (gap) drive(1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) drive(1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    serial_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if ({parallel_out, data_valid, comma_det, aligned} !== 13'd0) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d got po=%h dv=%b cd=%b al=%b exp all 0",
                 i, parallel_out, data_valid, comma_det, aligned);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    serial_in = 1'b0;
    serial_valid = 1'b1;
    checks++;
    if ({parallel_out, data_valid, comma_det, aligned} !== 13'd0) begin
      failures++;
      $display("FAIL reset_last got po=%h dv=%b cd=%b al=%b exp all 0",
               parallel_out, data_valid, comma_det, aligned);
    end
    drive(1'b0, 1'b0);
    checks++;
    if ({parallel_out, data_valid, comma_det, aligned} !== 13'd0) begin
      failures++;
      $display("FAIL reset_release got po=%h dv=%b cd=%b al=%b exp all 0",
               parallel_out, data_valid, comma_det, aligned);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_acq_rdm();
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    send_word(P, 0, 1'b1, 1'b1);
    drive(1'b0, 1'b0);
    checks++;
    if ({parallel_out, data_valid, comma_det, aligned} !== {10'h17C, 3'b111}) begin
      failures++;
      $display("FAIL acq_rdm_first got po=%h dv=%b cd=%b al=%b exp po=17c dv=1 cd=1 al=1",
               parallel_out, data_valid, comma_det, aligned);
    end
    send_word(10'h2AA, 0, 1'b1, 1'b0);
    drain();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL acq_rdm_drain got pending=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_acq_rdp_gaps();
    pulse_reset();
    send_word(N, 2, 1'b1, 1'b1);
    send_word(10'h155, 2, 1'b1, 1'b0);
    drain();
    checks++;
    if (sb.size() != 0 || aligned !== 1'b1) begin
      failures++;
      $display("FAIL acq_rdp_gaps got pending=%0d aligned=%b exp pending=0 aligned=1", sb.size(), aligned);
    end
  endtask

  task automatic test_boundary_commas();
    logic [9:0] w;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1) w = (i % 4 == 1) ? P : N;
      else            w = (i % 4 == 0) ? 10'h155 : 10'h2AA;
      send_word(w, 0, 1'b1, 1'(i % 2));
    end
    drain();
    checks++;
    if (sb.size() != 0 || aligned !== 1'b1) begin
      failures++;
      $display("FAIL boundary_commas got pending=%0d aligned=%b exp pending=0 aligned=1", sb.size(), aligned);
    end
  endtask

  task automatic test_loss_of_lock();
    logic [2:0] slip;
    logic [9:0] w;
    logic       exp_al;
    int         n;
    slip = 3'b011;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      drive(slip[i], 1'b1);
      n++;
    end
    for (int k = 1; k <= 6; k++) begin
      for (int j = 0; j < 10; j++) begin
        drive(P[j], 1'b1);
        n++;
        if (n % 10 == 0 && n <= 40) begin
          w = (n == 10) ? {P[6:0], slip} : {P[6:0], P[9:7]};
          sb.push_back({w, 1'b0, 1'b1});
        end
        if (n == 53 || n == 63) sb.push_back({P, 1'b1, 1'b1});
      end
      if (k <= 5) begin
        drive(1'b0, 1'b0);
        exp_al = (k < 4) || (k == 5);
        checks++;
        if (aligned !== exp_al) begin
          failures++;
          $display("FAIL loss_of_lock comma=%0d got aligned=%b exp=%b", k, aligned, exp_al);
        end
      end
    end
    drain();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL loss_of_lock_drain got pending=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] w;
    w = 10'h155;
    for (int i = 0; i < 5; i++) drive(w[i], 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    serial_in = w[5];
    serial_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    serial_valid = 1'b0;
    checks++;
    if ({parallel_out, data_valid, aligned} !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid got po=%h dv=%b al=%b exp all 0", parallel_out, data_valid, aligned);
    end
    for (int i = 5; i < 10; i++) drive(w[i], 1'b1);
    send_word(10'h2AA, 0, 1'b0, 1'b0);
    send_word(10'h155, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0);
    checks++;
    if (aligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hunt got aligned=%b exp=0", aligned);
    end
    send_word(P, 0, 1'b1, 1'b1);
    drain();
    checks++;
    if (sb.size() != 0 || aligned !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_relock got pending=%0d aligned=%b exp pending=0 aligned=1", sb.size(), aligned);
    end
  endtask

  initial begin
    test_reset();
    test_acq_rdm();
    test_acq_rdp_gaps();
    test_boundary_commas();
    test_loss_of_lock();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
